// File: rtl/seq_mul8.sv
// Radix-2 shift-and-add unsigned multiplier: N-bit x N-bit -> exact 2N-bit product.
// Latency: N cycles from the accept edge to out_valid; one operand pair in flight at a time.
// Backpressure: product and out_valid held until out_ready; in_ready only while idle.
module seq_mul8 #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset_b,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  mcand;
  logic [N:0]    acc;
  logic [N-1:0]  mplr;
  logic [CW-1:0] cnt;
  logic [N:0]    sum;
  logic          last_iter;

  // Partial-product add for the current multiplier LSB; acc[N] carries between steps.
  assign sum       = acc + (mplr[0] ? {1'b0, mcand} : '0);
  assign last_iter = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: capture on request, N iterations, hold result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs are pure functions of the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      BUSY:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: load operands on accept, then shift {sum, mplr} right once per cycle.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= x;
            mplr  <= y;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          acc  <= sum >> 1;
          mplr <= {sum[0], mplr[N-1:1]};
          cnt  <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Final acc[N] is always zero, so the low N bits of acc form the upper product half.
  assign p = {acc[N-1:0], mplr};

endmodule

// File: doc/seq_mul8.md
# seq_mul8

Radix-2 shift-and-add unsigned sequential multiplier. It takes two N-bit operands and produces the 2N-bit product one partial-product bit per clock. It is the producer end of the datapath: its 2N-bit result feeds the downstream round-to-nearest-even narrowing stage. Operands enter and products leave through valid/ready handshakes.

## Interface
- N, default 8: operand width. The product is 2N bits. N ≥ 2.
- clk  in  1  clock; all state changes on the rising edge.
- reset_b  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair x/y is valid.
- in_ready  out  1  block can accept an operand pair.
- x  in  N  multiplicand, unsigned.
- y  in  N  multiplier, unsigned.
- out_valid  out  1  product p is valid.
- out_ready  in  1  consumer takes p.
- p  out  2N  product x*y, unsigned, exact (no rounding, no truncation).
- busy  out  1  iteration in progress.

## Operation
- State register with three states: IDLE, BUSY, DONE.
- Internal registers:
  - mcand (N bits)
  - acc (N+1 bits: upper product half plus carry)
  - mplr (N bits: lower product half / remaining multiplier bits)
  - cnt (ceil(log2(N+1)) bits)
- IDLE:
  - in_ready=1.
  - On in_valid=1: mcand←x, mplr←y, acc←0, cnt←0, go to BUSY.
- BUSY, one iteration per cycle:
  - sum = acc + (mplr[0] ? {0,mcand} : 0).
  - Shift {sum, mplr} right by 1: acc←sum>>1, mplr←{sum[0], mplr[N-1:1]}.
  - cnt←cnt+1.
  - When cnt==N-1 in the current cycle, the iteration completes and the next state is DONE.
- DONE:
  - out_valid=1; p={acc[N-1:0], mplr}.
  - Held stable until out_ready=1, then go to IDLE.
- in_ready=1 only in IDLE. in_valid in BUSY/DONE is ignored; the operands are not captured.
- busy=1 only in BUSY.
- p is driven from registers in all states. It is only meaningful when out_valid=1.
- The carry is retained in acc[N] during iteration. Final acc[N] is always 0, since (2^N−1)² < 2^2N.
- Max product (2^N−1)² must come out exact, e.g. N=8 → 0xFE01.

## Timing
- Reset (reset_b=0 at an edge), values after that edge:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - acc=0, mplr=0, mcand=0, cnt=0, p=0.
- Reset overrides everything, including mid-BUSY and in DONE with out_ready=1. The in-flight product is discarded and no out_valid pulse occurs.
- Accept at edge t (in_valid & in_ready): BUSY from t+1, iterations at edges t+1…t+N, DONE with out_valid=1 after edge t+N.
  - Latency from the accept edge to out_valid is N cycles.
- Output handshake: transfer at the edge where out_valid & out_ready. in_ready rises after that edge.
  - No accept in the same cycle as output transfer.
  - Min spacing between accepts is N+2 cycles (N BUSY, ≥1 DONE, 1 IDLE).
- out_ready=0 in DONE: p and out_valid are held indefinitely, bit-stable.
- out_ready is ignored outside DONE.
- x and y may change freely after the accept edge; they are sampled only at accept.
- in_valid held high across DONE→IDLE: the next pair is accepted at the first IDLE edge.

## Test plan
- Reset, then x=0xFF, y=0xFF, in_valid one cycle, out_ready=1 → in_ready=0 for 9 cycles; out_valid high exactly 8 cycles after the accept edge with p=0xFE01; in_ready high the following cycle.
- Products x=0x00,y=0x5A → p=0x0000; x=0x80,y=0x02 → p=0x0100; x=0x0D,y=0xB7 → p=0x094B; x=0x01,y=0xFF → p=0x00FF.
- Backpressure: x=0x12,y=0x34 with out_ready=0 for 20 cycles after out_valid → p=0x03A8 stable, out_valid stays 1, in_ready stays 0; out_ready=1 for one cycle → out_valid=0 next cycle.
- Ignored input: accept x=0x03,y=0x05; during BUSY drive in_valid=1, x=0xFF, y=0xFF → result p=0x000F; the second pair is accepted only after the transfer (IDLE), giving p=0xFE01.
- Reset mid-op: accept x=0xAA,y=0x55, assert reset_b=0 at the 4th BUSY edge → next cycle out_valid=0, in_ready=1, p=0; a new pair 0x02×0x03 yields p=0x0006 with normal latency.
- Randomized sweep with N=8 and N=4, with random out_ready stalls and in_valid gaps → every p equals x*y, and exactly one transfer per accept.
